// File: rtl/axis_read_arb.sv
// Round-robin arbiter that shares one AXI read master port (AR + R) between
// NUM_PORTS axis_read engines. AR requests are registered onto the master
// channel tagged with the port index as ARID; R beats are steered back by RID.
module axis_read_arb #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned IDX_WIDTH      = 1,
  parameter int unsigned AXI_ID_WIDTH   = 8,
  parameter int unsigned AXI_LEN_WIDTH  = 8,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_PORTS*AXI_LEN_WIDTH-1:0]  s_arlen,
  input  logic [NUM_PORTS-1:0]                s_arvalid,
  output logic [NUM_PORTS-1:0]                s_arready,
  input  logic                                m_arready,
  output logic [AXI_ID_WIDTH-1:0]             m_arid,
  output logic [AXI_ADDR_WIDTH-1:0]           m_araddr,
  output logic [AXI_LEN_WIDTH-1:0]            m_arlen,
  output logic                                m_arvalid,
  input  logic [AXI_ID_WIDTH-1:0]             m_rid,
  input  logic                                m_rresp,
  input  logic                                m_rlast,
  input  logic [AXI_DATA_WIDTH-1:0]           m_rdata,
  input  logic                                m_rvalid,
  output logic                                m_rready,
  output logic [NUM_PORTS-1:0]                s_rvalid,
  input  logic [NUM_PORTS-1:0]                s_rready,
  output logic                                id_err
);

  logic [IDX_WIDTH-1:0]      ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]      grant, cand;
  logic                      any_valid;
  logic                      load;
  logic                      m_arvalid_q, m_arvalid_d;
  logic [AXI_ID_WIDTH-1:0]   m_arid_q, m_arid_d;
  logic [AXI_ADDR_WIDTH-1:0] m_araddr_q, m_araddr_d;
  logic [AXI_LEN_WIDTH-1:0]  m_arlen_q, m_arlen_d;
  logic [AXI_ADDR_WIDTH-1:0] grant_addr;
  logic [AXI_LEN_WIDTH-1:0]  grant_len;
  logic                      id_err_q, id_err_d;
  logic [IDX_WIDTH-1:0]      sel;
  logic                      in_range;

  // Data, resp and last are broadcast straight to the engines; not needed here.
  logic unused_r;
  assign unused_r = ^{m_rresp, m_rlast, m_rdata};

  // Output register can take a new beat when empty or draining this cycle.
  assign load = ~m_arvalid_q | m_arready;

  // Round-robin search starting at ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = IDX_WIDTH'((32'(ptr_q) + k) % NUM_PORTS);
      if (!any_valid && s_arvalid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  // Mux the granted port's address and length.
  always_comb begin
    grant_addr = '0;
    grant_len  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant == IDX_WIDTH'(i)) begin
        grant_addr = s_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        grant_len  = s_arlen[i*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
      end
    end
  end

  // AR next state: reload on a grant, empty on an idle load, otherwise hold.
  always_comb begin
    s_arready   = '0;
    ptr_d       = ptr_q;
    m_arvalid_d = m_arvalid_q;
    m_arid_d    = m_arid_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    if (load) begin
      if (any_valid) begin
        s_arready[grant] = 1'b1;
        m_arvalid_d      = 1'b1;
        m_arid_d         = AXI_ID_WIDTH'(grant);
        m_araddr_d       = grant_addr;
        m_arlen_d        = grant_len;
        ptr_d            = (32'(grant) == NUM_PORTS - 1) ? '0 : grant + IDX_WIDTH'(1);
      end else begin
        m_arvalid_d = 1'b0;
      end
    end
  end

  // R steering by RID; out-of-range beats are sunk and flagged.
  assign sel      = m_rid[IDX_WIDTH-1:0];
  assign in_range = ((m_rid >> IDX_WIDTH) == '0) && (32'(sel) < NUM_PORTS);

  always_comb begin
    s_rvalid = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      s_rvalid[i] = m_rvalid & in_range & (sel == IDX_WIDTH'(i));
    end
    m_rready = in_range ? s_rready[sel] : 1'b1;
    id_err_d = id_err_q | (m_rvalid & ~in_range);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      m_arvalid_q <= 1'b0;
      m_arid_q    <= '0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      id_err_q    <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      m_arvalid_q <= m_arvalid_d;
      m_arid_q    <= m_arid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      id_err_q    <= id_err_d;
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_arid    = m_arid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign id_err    = id_err_q;

endmodule

// File: tb/tb_axis_read_arb.sv
// Bench for axis_read_arb: table-driven AR and R vectors with an AR scoreboard,
// plus a hand-written reset-while-stalled sequence.
module tb_axis_read_arb;

  localparam int unsigned NP  = 2;
  localparam int unsigned IW  = 1;
  localparam int unsigned IDW = 8;
  localparam int unsigned LW  = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  a0, a1;
  logic [LW-1:0]  l0, l1;
  logic [NP-1:0]  s_arvalid, s_arready;
  logic           m_arready;
  logic [IDW-1:0] m_arid;
  logic [AW-1:0]  m_araddr;
  logic [LW-1:0]  m_arlen;
  logic           m_arvalid;
  logic [IDW-1:0] m_rid;
  logic           m_rresp, m_rlast, m_rvalid, m_rready;
  logic [DW-1:0]  m_rdata;
  logic [NP-1:0]  s_rvalid, s_rready;
  logic           id_err;

  always #5 clk = ~clk;

  axis_read_arb #(
    .NUM_PORTS(NP), .IDX_WIDTH(IW), .AXI_ID_WIDTH(IDW),
    .AXI_LEN_WIDTH(LW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_araddr({a1, a0}), .s_arlen({l1, l0}),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arvalid(m_arvalid),
    .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .id_err(id_err)
  );

  typedef struct {
    logic [1:0] v;
    logic       mrdy;
    logic [1:0] esr;
    logic       emv;
  } ar_vec_t;

  typedef struct {
    logic [7:0] rid;
    logic       rv;
    logic [1:0] rr;
    logic       last;
    logic [1:0] esv;
    logic       emr;
    logic       eerr;
  } r_vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
  } ar_exp_t;

  ar_vec_t arv[19];
  r_vec_t  rv[11];
  ar_exp_t sb[$];
  ar_exp_t e;
  int      nvec = 0;
  int      nerr = 0;
  int      delivered = 0;

  function automatic logic [AW-1:0] addr_of(input int p, input int i);
    return (p == 0) ? 32'h0000_1000 + 32'(i) * 32'h100 : 32'h8000_0000 + 32'(i) * 4;
  endfunction

  function automatic logic [LW-1:0] len_of(input int p, input int i);
    return (p == 0) ? 8'd15 + 8'(i) : 8'd100 + 8'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // AR vectors: {s_arvalid, m_arready, expected s_arready, expected m_arvalid}
    arv[0]  = '{2'b01, 1'b1, 2'b01, 1'b0};  // port 0 alone, empty output
    arv[1]  = '{2'b00, 1'b1, 2'b00, 1'b1};
    arv[2]  = '{2'b10, 1'b1, 2'b10, 1'b0};  // leaves ptr at 0
    arv[3]  = '{2'b11, 1'b1, 2'b01, 1'b1};  // both: 0,1,0,1 back-to-back
    arv[4]  = '{2'b11, 1'b1, 2'b10, 1'b1};
    arv[5]  = '{2'b11, 1'b1, 2'b01, 1'b1};
    arv[6]  = '{2'b11, 1'b1, 2'b10, 1'b1};
    arv[7]  = '{2'b00, 1'b1, 2'b00, 1'b1};
    arv[8]  = '{2'b10, 1'b0, 2'b10, 1'b0};  // port 1 loads into empty register
    arv[9]  = '{2'b10, 1'b0, 2'b00, 1'b1};  // stalled five cycles
    arv[10] = '{2'b10, 1'b0, 2'b00, 1'b1};
    arv[11] = '{2'b10, 1'b0, 2'b00, 1'b1};
    arv[12] = '{2'b10, 1'b0, 2'b00, 1'b1};
    arv[13] = '{2'b10, 1'b0, 2'b00, 1'b1};
    arv[14] = '{2'b10, 1'b1, 2'b10, 1'b1};  // drains and reloads
    arv[15] = '{2'b01, 1'b1, 2'b01, 1'b1};
    arv[16] = '{2'b00, 1'b1, 2'b00, 1'b1};
    arv[17] = '{2'b01, 1'b1, 2'b01, 1'b0};  // ptr=1, idle port 1 skipped
    arv[18] = '{2'b00, 1'b1, 2'b00, 1'b1};

    // R vectors: {rid, rvalid, s_rready, rlast, exp s_rvalid, exp m_rready, exp id_err}
    rv[0]  = '{8'd1, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0};
    rv[1]  = '{8'd1, 1'b1, 2'b01, 1'b0, 2'b10, 1'b0, 1'b0};
    rv[2]  = '{8'd1, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0};
    rv[3]  = '{8'd1, 1'b1, 2'b11, 1'b0, 2'b10, 1'b1, 1'b0};
    rv[4]  = '{8'd1, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0};
    rv[5]  = '{8'd0, 1'b1, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0};
    rv[6]  = '{8'd0, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0};
    rv[7]  = '{8'd0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0};
    rv[8]  = '{8'd2, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};  // bad RID but no valid
    rv[9]  = '{8'd3, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0};  // bad RID, dropped
    rv[10] = '{8'd1, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1'b1};

    rst       = 1'b1;
    s_arvalid = '0;
    m_arready = 1'b0;
    a0 = '0; a1 = '0; l0 = '0; l1 = '0;
    m_rid = '0; m_rresp = 1'b0; m_rlast = 1'b0; m_rdata = 32'hDEAD_BEEF;
    m_rvalid = 1'b0; s_rready = '0;
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("reset m_arvalid", 64'(m_arvalid), 64'd0);
    chk("reset m_arid", 64'(m_arid), 64'd0);
    chk("reset m_araddr", 64'(m_araddr), 64'd0);
    chk("reset m_arlen", 64'(m_arlen), 64'd0);
    chk("reset id_err", 64'(id_err), 64'd0);
    tick();

    // AR path: table plus scoreboard of granted requests
    for (int i = 0; i < 19; i++) begin
      s_arvalid = arv[i].v;
      m_arready = arv[i].mrdy;
      a0 = addr_of(0, i); l0 = len_of(0, i);
      a1 = addr_of(1, i); l1 = len_of(1, i);
      #2;
      chk($sformatf("ar[%0d] s_arready", i), 64'(s_arready), 64'(arv[i].esr));
      chk($sformatf("ar[%0d] m_arvalid", i), 64'(m_arvalid), 64'(arv[i].emv));
      if (m_arvalid && m_arready) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL ar[%0d] unexpected AR: got id %0h expected none", i, m_arid);
        end else begin
          e = sb.pop_front();
          chk($sformatf("ar[%0d] m_arid", i), 64'(m_arid), 64'(e.id));
          chk($sformatf("ar[%0d] m_araddr", i), 64'(m_araddr), 64'(e.addr));
          chk($sformatf("ar[%0d] m_arlen", i), 64'(m_arlen), 64'(e.len));
        end
      end else if (m_arvalid && sb.size() != 0) begin
        chk($sformatf("ar[%0d] stall m_araddr", i), 64'(m_araddr), 64'(sb[0].addr));
        chk($sformatf("ar[%0d] stall m_arid", i), 64'(m_arid), 64'(sb[0].id));
      end
      if (arv[i].esr[1]) sb.push_back('{8'd1, addr_of(1, i), len_of(1, i)});
      else if (arv[i].esr[0]) sb.push_back('{8'd0, addr_of(0, i), len_of(0, i)});
      tick();
    end
    s_arvalid = '0;
    chk("ar scoreboard drained", 64'(sb.size()), 64'd0);

    // R path: combinational steering and the sticky ID error
    for (int i = 0; i < 11; i++) begin
      m_rid    = rv[i].rid;
      m_rvalid = rv[i].rv;
      s_rready = rv[i].rr;
      m_rlast  = rv[i].last;
      #2;
      chk($sformatf("r[%0d] s_rvalid", i), 64'(s_rvalid), 64'(rv[i].esv));
      chk($sformatf("r[%0d] m_rready", i), 64'(m_rready), 64'(rv[i].emr));
      chk($sformatf("r[%0d] id_err", i), 64'(id_err), 64'(rv[i].eerr));
      if (i < 5 && s_rvalid[1] && s_rready[1]) delivered++;
      tick();
    end
    chk("rid1 beats delivered", 64'(delivered), 64'd4);
    m_rvalid = 1'b0;
    s_rready = '0;
    m_rlast  = 1'b0;
    tick();
    tick();
    #2;
    chk("id_err sticky", 64'(id_err), 64'd1);
    tick();

    // Reset while the output register is stalled; ptr returns to port 0
    s_arvalid = 2'b11;
    m_arready = 1'b0;
    a0 = 32'hAAAA_0000; l0 = 8'd3;
    a1 = 32'hBBBB_0000; l1 = 8'd7;
    #2;
    chk("pre-rst s_arready", 64'(s_arready), 64'b10);
    tick();
    #2;
    chk("pre-rst m_arvalid", 64'(m_arvalid), 64'd1);
    chk("pre-rst m_arid", 64'(m_arid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("post-rst m_arvalid", 64'(m_arvalid), 64'd0);
    chk("post-rst m_araddr", 64'(m_araddr), 64'd0);
    chk("post-rst id_err", 64'(id_err), 64'd0);
    chk("post-rst s_arready", 64'(s_arready), 64'b01);
    tick();
    #2;
    chk("post-rst grant m_arvalid", 64'(m_arvalid), 64'd1);
    chk("post-rst grant m_arid", 64'(m_arid), 64'd0);
    chk("post-rst grant m_araddr", 64'(m_araddr), 64'hAAAA_0000);
    s_arvalid = '0;
    m_arready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
